// File: rtl/mem_arbiter_if.sv
// Cache/RAM bundle for the two-master memory arbiter.
// The slave modport is the arbiter's view; master is the caches/RAM side.
interface mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;

   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   logic        timeout;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between icache and dcache for one RAM port; dcache
// bursts of up to BURST_LEN words hold the grant, with a sticky wait timeout.
module mem_arbiter #(
   parameter int BURST_LEN = 2,
   parameter int TIMEOUT   = 255
) (
   input logic          CLK,
   input logic          nRST,
   mem_arbiter_if.slave bus
);

   localparam int BW = $clog2(BURST_LEN) + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DSERVE = 2'd1;
   localparam logic [1:0] ST_ISERVE = 2'd2;

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [BW-1:0] r_beat;
   logic [BW-1:0] w_beat_nxt;
   logic [BW-1:0] w_beat_inc;
   logic          r_last_grant;
   logic          w_last_grant_nxt;
   logic [7:0]    r_wcnt;
   logic [7:0]    w_wcnt_nxt;
   logic          r_timeout;

   logic w_dpend;
   logic w_ipend;
   logic w_access;
   logic w_waiting;

   assign w_dpend    = bus.dREN | bus.dWEN;
   assign w_ipend    = bus.iREN;
   assign w_access   = (bus.ramstate == RAM_ACCESS);
   assign w_beat_inc = r_beat + BW'(1);

   always_comb begin
      // NOTE: every next-state value is defaulted before the case so no latch is inferred.
      w_state_nxt      = r_state;
      w_beat_nxt       = r_beat;
      w_last_grant_nxt = r_last_grant;
      w_waiting        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_dpend && w_ipend) begin
               w_state_nxt = (r_last_grant == GRANT_I) ? ST_DSERVE : ST_ISERVE;
            end else if (w_dpend) begin
               w_state_nxt = ST_DSERVE;
            end else if (w_ipend) begin
               w_state_nxt = ST_ISERVE;
            end
         end

         ST_DSERVE: begin
            if (!w_dpend) begin
               w_state_nxt = ST_IDLE;
               w_beat_nxt  = '0;
               if (r_beat != '0) begin
                  w_last_grant_nxt = GRANT_D;
               end
            end else if (w_access) begin
               // Burst lock: the icache waits until the dcache has its full burst.
               if (w_beat_inc == BEAT_LAST) begin
                  w_state_nxt      = ST_IDLE;
                  w_beat_nxt       = '0;
                  w_last_grant_nxt = GRANT_D;
               end else begin
                  w_beat_nxt = w_beat_inc;
               end
            end else begin
               w_waiting = 1'b1;
            end
         end

         ST_ISERVE: begin
            if (!w_ipend) begin
               w_state_nxt = ST_IDLE;
            end else if (w_access) begin
               w_state_nxt      = ST_IDLE;
               w_last_grant_nxt = GRANT_I;
            end else begin
               w_waiting = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_beat_nxt  = '0;
         end
      endcase
   end

   // Wait counter runs only while a granted request is being retried.
   always_comb begin
      w_wcnt_nxt = 8'd0;
      if (w_waiting) begin
         w_wcnt_nxt = (r_wcnt == 8'hFF) ? 8'hFF : r_wcnt + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state      <= ST_IDLE;
         r_beat       <= '0;
         r_last_grant <= GRANT_I;
         r_wcnt       <= 8'd0;
         r_timeout    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         r_state      <= w_state_nxt;
         r_beat       <= w_beat_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_wcnt       <= w_wcnt_nxt;
         if (w_waiting && (int'(w_wcnt_nxt) >= TIMEOUT)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = 32'd0;
      bus.ramstore = 32'd0;
      bus.iwait    = 1'b1;
      bus.iload    = 32'd0;
      bus.dwait    = 1'b1;
      bus.dload    = 32'd0;

      case (r_state)
         ST_DSERVE: begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            bus.dwait    = ~w_access;
            bus.dload    = bus.ramload;
         end
         ST_ISERVE: begin
            bus.ramaddr = bus.iaddr;
            bus.ramREN  = bus.iREN;
            bus.iwait   = ~w_access;
            bus.iload   = bus.ramload;
         end
         default: begin
         end
      endcase
   end

   assign bus.timeout = r_timeout;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 2: maximum consecutive dcache words served under one grant.
REQ-002 SHALL have parameter TIMEOUT, default 255: wait-cycle limit per granted request before the timeout flag sets.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-004 CLK  in  1  clock; all state updates on posedge.
REQ-005 nRST  in  1  asynchronous active-low reset.
REQ-006 iREN  in  1  icache read request; iaddr  in  32  icache word address.
REQ-007 iwait  out  1  icache stall; iload  out  32  icache read data.
REQ-008 dREN, dWEN  in  1 each  dcache read and write requests; daddr  in  32; dstore  in  32.
REQ-009 dwait  out  1  dcache stall; dload  out  32  dcache read data.
REQ-010 ramREN, ramWEN  out  1 each; ramaddr  out  32; ramstore  out  32.
REQ-011 ramload  in  32  RAM read data; ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-012 timeout  out  1  sticky flag: a granted request exceeded TIMEOUT wait cycles.

Function
REQ-013 SHALL implement FSM states IDLE, DSERVE, ISERVE plus registers beat (clog2(BURST_LEN)+1 bits), last_grant (I/D), wcnt (8 bits), timeout.
REQ-014 IDLE: no RAM strobes; iwait=dwait=1; iload=dload=0.
REQ-015 IDLE arbitration: exactly one pending requester -> grant it next cycle; both pending -> grant the one not equal to last_grant.
REQ-016 Pending dcache means dREN|dWEN; pending icache means iREN.
REQ-017 DSERVE: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both high).
REQ-018 DSERVE: dwait=~(ramstate==ACCESS); dload=ramload; iwait=1, iload=0.
REQ-019 ISERVE: ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0; iwait=~(ramstate==ACCESS); iload=ramload; dwait=1, dload=0.
REQ-020 DSERVE on ACCESS: beat increments; if new beat==BURST_LEN -> IDLE, beat=0, last_grant=D; else stay DSERVE (burst lock, icache cannot preempt).
REQ-021 DSERVE with dREN|dWEN low: -> IDLE next cycle, beat=0, last_grant=D if beat>0; RAM strobes deasserted that same cycle.
REQ-022 ISERVE on ACCESS -> IDLE, last_grant=I; ISERVE with iREN low -> IDLE, last_grant unchanged.
REQ-023 BUSY and ERROR SHALL keep wait high with strobes held, i.e. the request is retried until ACCESS.
REQ-024 wcnt SHALL increment each DSERVE/ISERVE cycle without ACCESS, saturate at 255, and clear on ACCESS or IDLE entry.
REQ-025 timeout SHALL set when wcnt reaches TIMEOUT and stay set until reset; arbitration is unaffected.
REQ-026 Grant latency SHALL be exactly one cycle from request in IDLE to strobe on RAM; minimum single-word service is 2 cycles.

Reset
REQ-027 While nRST=0: state=IDLE, beat=0, last_grant=I (dcache wins first tie), wcnt=0, timeout=0.
REQ-028 Reset outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
REQ-029 Reset asserted mid-service SHALL abort immediately, with no further RAM strobes after nRST falls.

Verification
REQ-030 Tie after reset: iREN=1, dREN=1 together, ramstate=ACCESS -> cycle 1 ramREN=1, ramaddr=daddr, dwait=0; icache stays stalled.
REQ-031 Burst lock: dREN held, daddr 0x40 then 0x44, iREN=1 -> both dcache words served back-to-back; then IDLE; then ISERVE (round robin).
REQ-032 Write priority: dREN=dWEN=1, daddr=0x3100, dstore=0x5 -> ramWEN=1, ramREN=0, ramstore=0x5.
REQ-033 Latency: ramstate BUSY 3 cycles then ACCESS, ramload=0xDEADBEEF -> dwait=1 for 3 cycles, then dwait=0 with dload=0xDEADBEEF.
REQ-034 Timeout: TIMEOUT=4, ramstate=ERROR held -> timeout=1 after 4 wait cycles and stays 1 after ACCESS; nRST pulse clears it.
REQ-035 Abort: dcache request withdrawn after 1 BUSY cycle -> ramREN=0 same cycle; state IDLE next cycle; pending iREN granted the following cycle.
